// File: rtl/io_pkg.sv
// Shared definitions for the I/O input-capture path: FSM state encoding
// and the width of the processor-side data word.
package io_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        DONE         = 2'd2,
        WAIT_RELEASE = 2'd3
    } cap_state_t;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counter debouncer for an active-low push-button.
// Emits a one-cycle press_evt when the debounced level goes 1 -> 0.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic debounced,
    output logic press_evt
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // Synchroniser: bring the asynchronous button into the clock domain; idles released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Debouncer: accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            debounced <= 1'b1;
            press_evt <= 1'b0;
        end else begin
            press_evt <= 1'b0;
            if (sync_p1 != debounced) begin
                if (cnt == CNT_LAST) begin
                    debounced <= sync_p1;
                    cnt       <= '0;
                    // Only the falling (press) edge is reported; releases are silent.
                    press_evt <= ~sync_p1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/io_input_capture.sv
// Input-capture stage ahead of the I/O module: waits for a debounced press of
// the Set button while an IN instruction is pending, latches the switches as a
// 32-bit word and stalls the processor until that word is delivered.
module io_input_capture
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SW_WIDTH        = 13,
    parameter bit SIGN_EXTEND     = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  SetRaw,
    input  logic [SW_WIDTH-1:0]   Switches,
    input  logic                  InReq,
    output logic                  Block,
    output logic [DATA_WIDTH-1:0] DataIO,
    output logic                  DataValid,
    output logic                  Waiting
);

    cap_state_t state;
    cap_state_t next_state;
    logic       capture;
    logic       debounced;
    logic       press_evt;

    // Widen the switch bus to the processor word, filling with the top switch or zero.
    function automatic logic [DATA_WIDTH-1:0] extend(input logic [SW_WIDTH-1:0] sw);
        logic fill;
        fill = SIGN_EXTEND ? sw[SW_WIDTH-1] : 1'b0;
        return {{(DATA_WIDTH - SW_WIDTH){fill}}, sw};
    endfunction

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (Clock),
        .rst_n     (Reset),
        .btn_raw   (SetRaw),
        .debounced (debounced),
        .press_evt (press_evt)
    );

    // State register.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a request withdrawn in the press cycle wins over the capture.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (InReq) begin
                    next_state = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (!InReq) begin
                    next_state = IDLE;
                end else if (press_evt) begin
                    capture    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = debounced ? IDLE : WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (debounced) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture register and delivery strobe; DataIO holds between captures.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            DataIO    <= '0;
            DataValid <= 1'b0;
        end else begin
            DataValid <= capture;
            if (capture) begin
                DataIO <= extend(Switches);
            end
        end
    end

    assign Block   = InReq & (state != DONE);
    assign Waiting = (state == WAIT_PRESS);

endmodule

// File: tb/tb_io_input_capture.sv
// Directed bench for io_input_capture: reset, capture latency, sign/zero
// extension, bounce rejection, held button, idle press and aborted request.
module tb_io_input_capture;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        SetRaw = 1'b1;
    logic        InReq = 1'b0;
    logic [12:0] Switches = '0;

    logic        Block, DataValid, Waiting;
    logic [31:0] DataIO;
    logic        Block_z, DataValid_z, Waiting_z;
    logic [31:0] DataIO_z;

    int total  = 0;
    int passed = 0;
    int n, dv_cnt, blk_low, wait_low;

    io_input_capture #(.DEBOUNCE_CYCLES(16), .SW_WIDTH(13), .SIGN_EXTEND(1'b1)) dut (
        .Clock(Clock), .Reset(Reset), .SetRaw(SetRaw), .Switches(Switches), .InReq(InReq),
        .Block(Block), .DataIO(DataIO), .DataValid(DataValid), .Waiting(Waiting)
    );

    io_input_capture #(.DEBOUNCE_CYCLES(16), .SW_WIDTH(13), .SIGN_EXTEND(1'b0)) dut_z (
        .Clock(Clock), .Reset(Reset), .SetRaw(SetRaw), .Switches(Switches), .InReq(InReq),
        .Block(Block_z), .DataIO(DataIO_z), .DataValid(DataValid_z), .Waiting(Waiting_z)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Wait up to max negedges for a DataValid strobe; n = cycle index or 0 on timeout.
    task automatic wait_dv(input int max, output int cyc);
        cyc = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge Clock);
            if (DataValid === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Run n cycles counting strobes and cycles with Block or Waiting not high.
    task automatic run_quiet(input int cycles, output int dv, output int bl, output int wl);
        dv = 0; bl = 0; wl = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clock);
            if (DataValid !== 1'b0) dv++;
            if (Block !== 1'b1) bl++;
            if (Waiting !== 1'b1) wl++;
        end
    endtask

    initial begin
        int dv_acc, bl_acc, wl_acc;

        // Reset held with button pressed and a request pending
        Reset = 1'b0; SetRaw = 1'b0; InReq = 1'b1; Switches = 13'h0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk("reset_dataio", DataIO, 32'h0);
            chk("reset_dv", {31'b0, DataValid}, 32'h0);
        end
        chk("reset_block", {31'b0, Block}, 32'h1);
        chk("reset_waiting", {31'b0, Waiting}, 32'h0);

        Reset = 1'b1; SetRaw = 1'b1;
        @(negedge Clock);
        chk("post_reset_waiting", {31'b0, Waiting}, 32'h1);
        chk("post_reset_block", {31'b0, Block}, 32'h1);
        run_quiet(17, dv_cnt, blk_low, wait_low);
        chk("post_reset_no_dv", dv_cnt, 0);
        chk("post_reset_wait_low", wait_low, 0);

        // Basic capture: strobe 19 cycles after the button falls
        Switches = 13'h0005; SetRaw = 1'b0;
        wait_dv(40, n);
        chk("basic_latency", n, 19);
        chk("basic_dataio", DataIO, 32'h0000_0005);
        chk("basic_dataio_z", DataIO_z, 32'h0000_0005);
        chk("basic_block_done", {31'b0, Block}, 32'h0);
        run_quiet(21, dv_cnt, blk_low, wait_low);
        chk("basic_single_dv", dv_cnt, 0);
        chk("basic_block_after", blk_low, 0);
        SetRaw = 1'b1;
        run_quiet(25, dv_cnt, blk_low, wait_low);
        chk("basic_release_no_dv", dv_cnt, 0);
        chk("basic_rearmed_waiting", {31'b0, Waiting}, 32'h1);

        // Sign vs zero extension
        Switches = 13'h1FFF; SetRaw = 1'b0;
        wait_dv(40, n);
        chk("sext_latency", n, 19);
        chk("sext_dataio", DataIO, 32'hFFFF_FFFF);
        chk("zext_dataio", DataIO_z, 32'h0000_1FFF);
        SetRaw = 1'b1;
        run_quiet(25, dv_cnt, blk_low, wait_low);

        // Bounce rejection: 5-cycle toggles never reach the threshold
        dv_acc = 0; bl_acc = 0; wl_acc = 0;
        for (int k = 0; k < 12; k++) begin
            SetRaw = (k % 2 == 1);
            run_quiet(5, dv_cnt, blk_low, wait_low);
            dv_acc += dv_cnt; bl_acc += blk_low; wl_acc += wait_low;
        end
        SetRaw = 1'b1;
        run_quiet(20, dv_cnt, blk_low, wait_low);
        dv_acc += dv_cnt; bl_acc += blk_low; wl_acc += wait_low;
        chk("bounce_no_dv", dv_acc, 0);
        chk("bounce_block", bl_acc, 0);
        chk("bounce_waiting", wl_acc, 0);

        // Held button across back-to-back requests
        Switches = 13'h000A; SetRaw = 1'b0;
        wait_dv(40, n);
        chk("held_latency", n, 19);
        chk("held_dataio", DataIO, 32'h0000_000A);
        @(negedge Clock);
        chk("held_block_reassert", {31'b0, Block}, 32'h1);
        chk("held_waiting_low", {31'b0, Waiting}, 32'h0);
        run_quiet(30, dv_cnt, blk_low, wait_low);
        dv_acc = dv_cnt; bl_acc = blk_low;
        SetRaw = 1'b1;
        run_quiet(20, dv_cnt, blk_low, wait_low);
        dv_acc += dv_cnt; bl_acc += blk_low;
        chk("held_single_dv", dv_acc, 0);
        chk("held_block_stays", bl_acc, 0);
        chk("held_rearmed", {31'b0, Waiting}, 32'h1);
        Switches = 13'h0003; SetRaw = 1'b0;
        wait_dv(40, n);
        chk("second_latency", n, 19);
        chk("second_dataio", DataIO, 32'h0000_0003);

        // Press with no request pending is ignored
        InReq = 1'b0; SetRaw = 1'b1;
        run_quiet(25, dv_cnt, blk_low, wait_low);
        chk("idle_block", {31'b0, Block}, 32'h0);
        chk("idle_waiting", {31'b0, Waiting}, 32'h0);
        Switches = 13'h0777; SetRaw = 1'b0;
        run_quiet(30, dv_cnt, blk_low, wait_low);
        chk("idle_press_no_dv", dv_cnt, 0);
        chk("idle_dataio_held", DataIO, 32'h0000_0003);
        SetRaw = 1'b1;
        run_quiet(25, dv_cnt, blk_low, wait_low);

        // Request withdrawn in the same cycle as the press event
        Switches = 13'h0444; InReq = 1'b1; SetRaw = 1'b0;
        @(negedge Clock);
        chk("abort_armed", {31'b0, Waiting}, 32'h1);
        repeat (17) @(negedge Clock);
        InReq = 1'b0;
        @(negedge Clock);
        chk("abort_dv", {31'b0, DataValid}, 32'h0);
        chk("abort_waiting", {31'b0, Waiting}, 32'h0);
        chk("abort_block", {31'b0, Block}, 32'h0);
        run_quiet(10, dv_cnt, blk_low, wait_low);
        chk("abort_no_dv", dv_cnt, 0);
        chk("abort_dataio", DataIO, 32'h0000_0003);

        // Reset in the middle of a pending request
        InReq = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk("midreset_dataio", DataIO, 32'h0);
        chk("midreset_dv", {31'b0, DataValid}, 32'h0);
        chk("midreset_block", {31'b0, Block}, 32'h1);
        chk("midreset_waiting", {31'b0, Waiting}, 32'h0);
        Reset = 1'b1;
        @(negedge Clock);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
